// File: rtl/poly_derivative_sequencer_if.sv
// Term-in / derivative-out stream bundle for the polynomial derivative sequencer.
// slave is the sequencer's view; master is the producer/consumer side driving it.
interface poly_derivative_sequencer_if #(
  parameter int CW = 4,
  parameter int EW = 4
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_coef;
  logic [EW-1:0]    in_exp;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CW+EW-1:0] out_coef;
  logic [EW-1:0]    out_exp;
  logic             out_last;
  logic             busy;

  modport master (
    output clear, in_valid, in_coef, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_coef, out_exp, out_last, busy
  );

  modport slave (
    input  clear, in_valid, in_coef, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_coef, out_exp, out_last, busy
  );
endinterface

// File: rtl/poly_derivative_sequencer.sv
// Buffers up to N_TERMS (coef,exp) terms, then emits power-rule derivatives in input order.
// First output 1+leading-dropped cycles after last input; output held until out_ready, input stalled meanwhile.
module poly_derivative_sequencer #(
  parameter int N_TERMS = 4,
  parameter int CW      = 4,
  parameter int EW      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  poly_derivative_sequencer_if.slave  bus
);

  localparam int IW   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int CNTW = $clog2(N_TERMS + 1);
  localparam int OW   = CW + EW;

  typedef enum logic [1:0] {ST_LOAD, ST_SCAN, ST_EMIT} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_TERMS-1:0]  nz_q, nz_d;
  logic [CW-1:0]       coef_q [N_TERMS];
  logic [CW-1:0]       coef_d [N_TERMS];
  logic [EW-1:0]       exp_q  [N_TERMS];
  logic [EW-1:0]       exp_d  [N_TERMS];
  logic [OW-1:0]       ocoef_q, ocoef_d;
  logic [EW-1:0]       oexp_q, oexp_d;
  logic                olast_q, olast_d;
  logic [IW-1:0]       last_nz;
  logic [IW-1:0]       wr_idx;

  assign wr_idx       = count_q[IW-1:0];
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.busy      = (state_q == ST_SCAN) || (state_q == ST_EMIT);
  assign bus.out_coef  = ocoef_q;
  assign bus.out_exp   = oexp_q;
  assign bus.out_last  = olast_q;

  // Highest surviving term index; that term carries out_last.
  always_comb begin
    last_nz = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (nz_q[i]) last_nz = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    coef_d  = coef_q;
    exp_d   = exp_q;
    ocoef_d = ocoef_q;
    oexp_d  = oexp_q;
    olast_d = olast_q;

    if (bus.clear) begin
      state_d = ST_LOAD;
      count_d = '0;
      idx_d   = '0;
      nz_d    = '0;
      ocoef_d = '0;
      oexp_d  = '0;
      olast_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.in_valid) begin
            coef_d[wr_idx] = bus.in_coef;
            exp_d[wr_idx]  = bus.in_exp;
            nz_d[wr_idx]   = (bus.in_coef != '0) && (bus.in_exp != '0);
            count_d        = count_q + CNTW'(1);
            if (bus.in_last || (count_d == CNTW'(N_TERMS))) begin
              state_d = ST_SCAN;
              idx_d   = '0;
            end
          end
        end
        ST_SCAN: begin
          if (nz_q[idx_q]) begin
            ocoef_d = OW'(coef_q[idx_q]) * OW'(exp_q[idx_q]);
            oexp_d  = exp_q[idx_q] - EW'(1);
            olast_d = (idx_q == last_nz);
            state_d = ST_EMIT;
          end else if ((CNTW'(idx_q) + CNTW'(1)) == count_q) begin
            if (nz_q == '0) begin
              ocoef_d = '0;
              oexp_d  = '0;
              olast_d = 1'b1;
              state_d = ST_EMIT;
            end else begin
              // Cannot occur: a surviving term past idx would have been found first.
              state_d = ST_LOAD;
              count_d = '0;
              idx_d   = '0;
              nz_d    = '0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (olast_q) begin
              state_d = ST_LOAD;
              count_d = '0;
              idx_d   = '0;
              nz_d    = '0;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = ST_SCAN;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      idx_q   <= '0;
      nz_q    <= '0;
      ocoef_q <= '0;
      oexp_q  <= '0;
      olast_q <= 1'b0;
      for (int i = 0; i < N_TERMS; i++) begin
        coef_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      ocoef_q <= ocoef_d;
      oexp_q  <= oexp_d;
      olast_q <= olast_d;
      coef_q  <= coef_d;
      exp_q   <= exp_d;
    end
  end

endmodule

// File: tb/tb_poly_derivative_sequencer.sv
// Directed and randomized polynomials checked against a list-based power-rule model.
module tb_poly_derivative_sequencer;
  localparam int CW = 4;
  localparam int EW = 4;
  localparam int N  = 4;

  typedef struct {
    int c;
    int e;
    bit l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_derivative_sequencer_if #(.CW(CW), .EW(EW)) bus ();

  poly_derivative_sequencer #(.N_TERMS(N), .CW(CW), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  int    t_c [N];
  int    t_e [N];
  int    t_l [N];
  int    t_n;
  int    lat_exp;
  beat_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected output: every term with nonzero coef and exp becomes (c*e, e-1) in order;
  // an empty result is one 0x^0 beat.
  task automatic build_model();
    beat_t b;
    exp_q.delete();
    lat_exp = t_n;
    for (int i = 0; i < t_n; i++) begin
      if (t_c[i] != 0 && t_e[i] != 0) begin
        if (exp_q.size() == 0) lat_exp = 1 + i;
        b.c = t_c[i] * t_e[i];
        b.e = t_e[i] - 1;
        b.l = 1'b0;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() == 0) begin
      b.c = 0; b.e = 0; b.l = 1'b1;
      exp_q.push_back(b);
    end else begin
      b = exp_q[exp_q.size()-1];
      b.l = 1'b1;
      exp_q[exp_q.size()-1] = b;
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_term(input int c, input int e, input int l);
    bit acc;
    int w;
    bus.in_valid = 1'b1;
    bus.in_coef  = CW'(c);
    bus.in_exp   = EW'(e);
    bus.in_last  = l[0];
    acc = 1'b0;
    w   = 0;
    while (!acc && w < 50) begin
      acc = bus.in_ready;
      @(negedge clk);
      w++;
    end
    if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_poly();
    for (int i = 0; i < t_n; i++) send_term(t_c[i], t_e[i], t_l[i]);
  endtask

  task automatic collect(input bit stall_first, input bit rnd_ready);
    int w;
    beat_t b;
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("first_out_latency", w, lat_exp);
    for (int k = 0; k < exp_q.size(); k++) begin
      b = exp_q[k];
      if (stall_first && k == 0) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_coef", bus.out_coef, b.c);
          chk("stall_exp", bus.out_exp, b.e);
          @(negedge clk);
        end
      end
      w = 0;
      while (w < 200) begin
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_coef   = CW'($urandom);
        bus.in_exp    = EW'($urandom);
        if (bus.out_valid && bus.out_ready) break;
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        chk("out_timeout", 32'd0, 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        return;
      end
      chk("out_coef", bus.out_coef, b.c);
      chk("out_exp", bus.out_exp, b.e);
      chk("out_last", bus.out_last, b.l);
      chk("in_ready_while_emit", bus.in_ready, 0);
      chk("busy_while_emit", bus.busy, 1);
      if (b.l) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_busy", bus.busy, 0);
    chk("post_out_valid", bus.out_valid, 0);
  endtask

  task automatic run_poly(input bit stall_first, input bit rnd_ready);
    build_model();
    load_poly();
    collect(stall_first, rnd_ready);
  endtask

  task automatic set_term(input int i, input int c, input int e, input int l);
    t_c[i] = c;
    t_e[i] = e;
    t_l[i] = l;
  endtask

  initial begin
    int w;
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.in_exp    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_coef", bus.out_coef, 0);
    chk("rst_out_exp", bus.out_exp, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    t_n = 3;
    set_term(0, 3, 2, 0); set_term(1, 5, 1, 0); set_term(2, 7, 0, 1);
    run_poly(1'b0, 1'b0);

    t_n = 2;
    set_term(0, 0, 3, 0); set_term(1, 4, 0, 1);
    run_poly(1'b0, 1'b0);

    t_n = 4;
    set_term(0, 15, 15, 0); set_term(1, 1, 1, 0); set_term(2, 2, 3, 0); set_term(3, 9, 9, 0);
    run_poly(1'b1, 1'b0);

    // Abort while scanning, then a fresh polynomial must start from an empty buffer.
    t_n = 3;
    set_term(0, 0, 1, 0); set_term(1, 0, 2, 0); set_term(2, 3, 3, 1);
    load_poly();
    chk("scan_busy", bus.busy, 1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clear_in_ready", bus.in_ready, 1);
    chk("clear_busy", bus.busy, 0);
    chk("clear_out_valid", bus.out_valid, 0);
    t_n = 1;
    set_term(0, 2, 2, 1);
    run_poly(1'b0, 1'b0);

    // Asynchronous reset while a beat is pending.
    t_n = 1;
    set_term(0, 3, 2, 1);
    load_poly();
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pre_reset_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t_n = 2;
    set_term(0, 6, 4, 0); set_term(1, 1, 2, 1);
    run_poly(1'b0, 1'b1);

    for (int p = 0; p < 40; p++) begin
      t_n = $urandom_range(1, N);
      for (int i = 0; i < t_n; i++) begin
        set_term(i,
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                 (i == t_n - 1) ? ((t_n < N) ? 1 : int'($urandom_range(0, 1))) : 0);
      end
      run_poly(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
